stream_packer: RTL

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stream_packer.sv
// stream_packer: collects N_BYTES symbols of BYTE_W bits into one wide word
// and queues the completed words in a small first-word-fall-through FIFO.
// A frame-start strobe (sof) drops any partial word and restarts at index 0.
module stream_packer #(
    parameter int BYTE_W     = 8,
    parameter int N_BYTES    = 26,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            sof,
    input  logic                            din_vld,
    input  logic [BYTE_W-1:0]               din,
    input  logic                            dout_rdy,
    input  logic                            clr_err,
    output logic                            dout_vald,
    output logic [BYTE_W*N_BYTES-1:0]       parallel_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            frag_err,
    output logic [15:0]                     word_cnt
);

    localparam int WORD_W = BYTE_W * N_BYTES;
    localparam int K_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_BYTES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Input side state
    logic [K_W-1:0]    k_reg, k_next;
    logic [WORD_W-1:0] word_reg, word_next;

    // FIFO state
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg, level_next;

    // Flags and statistics
    logic              overflow_reg, frag_err_reg;
    logic [15:0]       word_cnt_reg;

    // Decoded per-cycle events
    logic              accept, resync, frag_set;
    logic [K_W-1:0]    eff_k;
    logic              push, pop, fifo_full, push_ok, overflow_set;

    assign accept   = en & din_vld;
    assign resync   = en & sof;
    // k is never nonzero when N_BYTES is 1, so resync cannot flag a fragment there.
    assign frag_set = resync & (k_reg != '0);
    // On resync the current symbol (if any) is treated as index 0.
    assign eff_k    = resync ? '0 : k_reg;

    assign push         = accept & (eff_k == K_LAST);
    assign pop          = dout_vald & dout_rdy;
    assign fifo_full    = (level_reg == LVL_FULL);
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign push_ok      = push & (~fifo_full | pop);
    assign overflow_set = push & fifo_full & ~pop;

    // Per-slice symbol capture; slice order depends on MSB_FIRST.
    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_slice
            localparam int SYM_IDX = (MSB_FIRST != 0) ? (N_BYTES - 1 - gi) : gi;
            assign word_next[gi*BYTE_W +: BYTE_W] =
                (accept && (eff_k == K_W'(SYM_IDX))) ? din : word_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Next symbol index: advance on accept, wrap after the last slice.
    always_comb begin
        k_next = eff_k;
        if (accept) begin
            if (eff_k == K_LAST) begin
                k_next = '0;
            end else begin
                k_next = eff_k + K_W'(1);
            end
        end
    end

    // Next occupancy; simultaneous push and pop cancel out.
    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Assembly register and symbol index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg    <= '0;
            word_reg <= '0;
        end else begin
            k_reg    <= k_next;
            word_reg <= word_next;
        end
    end

    // FIFO storage; the completed word includes the symbol accepted this edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= word_next;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
        end
    end

    // Sticky flags (set beats clear) and the accepted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            frag_err_reg <= 1'b0;
            word_cnt_reg <= '0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (frag_set) begin
                frag_err_reg <= 1'b1;
            end else if (clr_err) begin
                frag_err_reg <= 1'b0;
            end
            if (push_ok) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
            end
        end
    end

    // Head word is shown only while valid, so reset/empty reads as zero.
    assign dout_vald     = (level_reg != '0);
    assign parallel_data = dout_vald ? mem[rd_ptr_reg] : '0;
    assign fifo_level    = level_reg;
    assign overflow      = overflow_reg;
    assign frag_err      = frag_err_reg;
    assign word_cnt      = word_cnt_reg;

endmodule
